// File: rtl/mdu_exec_pkg.sv
// Shared encodings and default widths for the multiply/divide execution unit.
package mdu_exec_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

  // Divide ops occupy the upper half of the encoding space.
  function automatic logic op_is_div(mdu_op_e o);
    return o[2];
  endfunction
endpackage

// File: rtl/mdu_exec_if.sv
// Issue/writeback bundle between the pipeline (master) and the MDU (slave).
interface mdu_exec_if import mdu_exec_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [XLEN-1:0]   rs1_rdata;
  logic [XLEN-1:0]   rs2_rdata;
  logic [REG_AW-1:0] rd_waddr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] rd_waddr_o;
  logic [XLEN-1:0]   rd_wdata_o;
  logic              busy_o;

  modport master (
    output in_valid, op, rs1_rdata, rs2_rdata, rd_waddr, flush, out_ready,
    input  in_ready, out_valid, rd_waddr_o, rd_wdata_o, busy_o
  );
  modport slave (
    input  in_valid, op, rs1_rdata, rs2_rdata, rd_waddr, flush, out_ready,
    output in_ready, out_valid, rd_waddr_o, rd_wdata_o, busy_o
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on magnitudes.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);
  logic [XLEN:0] sum, r_sh, diff;

  always_comb begin
    sum     = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
    r_sh    = {acc, lo[XLEN-1]};
    diff    = r_sh - {1'b0, opb};
    acc_nxt = sum[XLEN:1];
    lo_nxt  = {sum[0], lo[XLEN-1:1]};
    if (is_div) begin
      // Partial remainder stays below the divisor, so XLEN bits always suffice.
      acc_nxt = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], ~diff[XLEN]};
    end
  end
endmodule

// File: rtl/mdu_exec.sv
// Iterative RV-style M-extension unit: one op in flight, XLEN-cycle multiply/divide.
module mdu_exec import mdu_exec_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mdu_exec_if.slave  mdu
);
  localparam int CNT_W = $clog2(XLEN + 1);

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_in;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   acc_q, lo_q, opb_q, res_q;
  logic [XLEN-1:0]   acc_nxt, lo_nxt;
  logic              neg_q, neg_r_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept, is_div_in, neg1, neg2, div_zero, div_ovf, special, last;
  logic [XLEN-1:0]   mag1, mag2, spec_res, q_s, r_s, fin;
  logic [2*XLEN-1:0] prod, prod_s;

  // Input decode and sign handling.
  always_comb begin
    op_in     = mdu_op_e'(mdu.op);
    is_div_in = op_is_div(op_in);
    neg1      = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & mdu.rs1_rdata[XLEN-1];
    neg2      = (op_in inside {OP_MULH, OP_DIV, OP_REM}) & mdu.rs2_rdata[XLEN-1];
    mag1      = neg1 ? -mdu.rs1_rdata : mdu.rs1_rdata;
    mag2      = neg2 ? -mdu.rs2_rdata : mdu.rs2_rdata;
    div_zero  = is_div_in && (mdu.rs2_rdata == '0);
    div_ovf   = (op_in inside {OP_DIV, OP_REM}) &&
                (mdu.rs1_rdata == {1'b1, {(XLEN-1){1'b0}}}) && (&mdu.rs2_rdata);
    special   = div_zero | div_ovf;
    spec_res  = '0;
    if (div_zero)     spec_res = op_in[1] ? mdu.rs1_rdata : '1;
    else if (div_ovf) spec_res = op_in[1] ? '0 : mdu.rs1_rdata;
    accept    = (state_q == S_IDLE) && mdu.in_valid && !mdu.flush && !rst;
    last      = (cnt_q == CNT_W'(XLEN - 1));
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_is_div(op_q)),
    .acc     (acc_q),
    .lo      (lo_q),
    .opb     (opb_q),
    .acc_nxt (acc_nxt),
    .lo_nxt  (lo_nxt)
  );

  // Result sign fix-up applied on the final step's outputs.
  always_comb begin
    prod   = {acc_nxt, lo_nxt};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -lo_nxt : lo_nxt;
    r_s    = neg_r_q ? -acc_nxt : acc_nxt;
    if (op_is_div(op_q)) fin = op_q[1] ? r_s : q_s;
    else                 fin = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (last) state_d = S_DONE;
      S_DONE:  if (mdu.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (mdu.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_MUL;
      rd_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      rd_q    <= mdu.rd_waddr;
      acc_q   <= '0;
      lo_q    <= is_div_in ? mag1 : mag2;
      opb_q   <= is_div_in ? mag2 : mag1;
      res_q   <= spec_res;
      neg_q   <= neg1 ^ neg2;
      neg_r_q <= neg1;
      cnt_q   <= '0;
    end else if (state_q == S_CALC) begin
      acc_q <= acc_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) res_q <= fin;
    end
  end

  assign mdu.in_ready   = (state_q == S_IDLE) && !rst;
  assign mdu.out_valid  = (state_q == S_DONE);
  assign mdu.busy_o     = (state_q != S_IDLE);
  assign mdu.rd_waddr_o = mdu.out_valid ? rd_q : '0;
  assign mdu.rd_wdata_o = mdu.out_valid ? res_q : '0;
endmodule

// File: tb/tb_mdu_exec.sv
// Scoreboard bench for mdu_exec: directed vectors on a 32-bit and a 16-bit build.
module tb_mdu_exec;
  import mdu_exec_pkg::*;

  typedef struct { logic [31:0] data; logic [4:0] rd; int lat; } exp_t;
  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] rd; logic [31:0] exp; int lat; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0, checks = 0, edges = 0, acc_edge = 0, acc16 = 0;
  exp_t sb[$];
  exp_t sb16[$];
  vec_t vt[16];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  mdu_exec_if #(.XLEN(32), .REG_AW(5)) m();
  mdu_exec_if #(.XLEN(16), .REG_AW(5)) m16();

  mdu_exec #(.XLEN(32), .REG_AW(5)) dut   (.clk(clk), .rst(rst), .mdu(m));
  mdu_exec #(.XLEN(16), .REG_AW(5)) dut16 (.clk(clk), .rst(rst), .mdu(m16));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    m.in_valid = 1'b1; m.op = op; m.rs1_rdata = a; m.rs2_rdata = b; m.rd_waddr = rd;
    @(posedge clk); #1;
    acc_edge = edges;
    // Scramble inputs after acceptance; the unit must have latched its own copy.
    m.in_valid = 1'b0; m.op = ~op; m.rs1_rdata = ~a; m.rs2_rdata = b ^ 32'h5a5a_1234; m.rd_waddr = ~rd;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    exp_t e;
    chk("in_ready_idle", 32'(m.in_ready), 32'd1);
    e.data = exp; e.rd = rd; e.lat = lat;
    sb.push_back(e);
    start(op, a, b, rd);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || m.out_valid) && n < 200) begin @(posedge clk); #2; n++; end
    chk("drain", 32'(sb.size()) + 32'(m.out_valid), 32'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m.out_valid && n < 100) begin @(posedge clk); #2; n++; end
    chk("wait_valid", 32'(m.out_valid), 32'd1);
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int lat);
    exp_t e;
    int n = 0;
    chk("in_ready16", 32'(m16.in_ready), 32'd1);
    e.data = exp; e.rd = 5'd3; e.lat = lat;
    sb16.push_back(e);
    m16.in_valid = 1'b1; m16.op = op; m16.rs1_rdata = a; m16.rs2_rdata = b; m16.rd_waddr = 5'd3;
    @(posedge clk); #1;
    acc16 = edges;
    m16.in_valid = 1'b0; m16.rs1_rdata = ~a;
    while ((sb16.size() != 0 || m16.out_valid) && n < 100) begin @(posedge clk); #2; n++; end
    chk("drain16", 32'(sb16.size()) + 32'(m16.out_valid), 32'd0);
  endtask

  // Monitor for the 32-bit unit: pops on the first valid cycle, then checks hold stability.
  initial begin : mon
    exp_t cur;
    bit   have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (m.out_valid) begin
        if (!have) begin
          if (sb.size() == 0) chk("spurious_valid", 32'(m.out_valid), 32'd0);
          else begin
            cur  = sb.pop_front();
            have = 1'b1;
            chk("latency", edges - acc_edge, cur.lat);
          end
        end
        if (have) begin
          chk("rd_wdata", m.rd_wdata_o, cur.data);
          chk("rd_waddr", 32'(m.rd_waddr_o), 32'(cur.rd));
          chk("in_ready_done", 32'(m.in_ready), 32'd0);
          if (m.out_ready) have = 1'b0;
        end
      end else begin
        have = 1'b0;
        chk("idle_wdata", m.rd_wdata_o, 32'd0);
        chk("idle_waddr", 32'(m.rd_waddr_o), 32'd0);
      end
    end
  end

  initial begin : mon16
    exp_t c;
    bit   h;
    h = 1'b0;
    forever begin
      @(negedge clk);
      if (!m16.out_valid) h = 1'b0;
      else if (!h) begin
        h = 1'b1;
        if (sb16.size() == 0) chk("spurious_valid16", 32'(m16.out_valid), 32'd0);
        else begin
          c = sb16.pop_front();
          chk("latency16", edges - acc16, c.lat);
          chk("rd_wdata16", 32'(m16.rd_wdata_o), c.data);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt = '{
      '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 32},
      '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd2,  32'h80000000, 0},
      '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd3,  32'h00000000, 0},
      '{OP_DIVU,   32'h00000007, 32'h00000000, 5'd4,  32'hFFFFFFFF, 0},
      '{OP_REMU,   32'h00000007, 32'h00000000, 5'd5,  32'h00000007, 0},
      '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFD, 32},
      '{OP_MUL,    32'h0000000F, 32'h00000003, 5'd0,  32'h0000002D, 32},
      '{OP_MULH,   32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 32},
      '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 32},
      '{OP_DIVU,   32'hFFFFFFFF, 32'h00000010, 5'd9,  32'h0FFFFFFF, 32},
      '{OP_REMU,   32'hFFFFFFFF, 32'h00000010, 5'd10, 32'h0000000F, 32},
      '{OP_DIV,    32'h00000064, 32'hFFFFFFF9, 5'd11, 32'hFFFFFFF2, 32},
      '{OP_REM,    32'h00000064, 32'hFFFFFFF9, 5'd12, 32'h00000002, 32},
      '{OP_REM,    32'hFFFFFFFB, 32'h00000000, 5'd13, 32'hFFFFFFFB, 0},
      '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'h00000001, 32},
      '{OP_MULH,   32'hFFFFFFF9, 32'h00000003, 5'd16, 32'hFFFFFFFF, 32}
    };
    m.in_valid = 1'b0; m.op = '0; m.rs1_rdata = '0; m.rs2_rdata = '0; m.rd_waddr = '0;
    m.flush = 1'b0; m.out_ready = 1'b1;
    m16.in_valid = 1'b0; m16.op = '0; m16.rs1_rdata = '0; m16.rs2_rdata = '0; m16.rd_waddr = '0;
    m16.flush = 1'b0; m16.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(m.out_valid), 32'd0);
    chk("rst_busy", 32'(m.busy_o), 32'd0);
    chk("rst_in_ready", 32'(m.in_ready), 32'd0);
    chk("rst_wdata", m.rd_wdata_o, 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(m.in_ready), 32'd1);
    @(posedge clk); #2;

    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].rd, vt[i].exp, vt[i].lat);
      wait_done();
    end

    // Consumer stalls for five cycles; result must hold steady.
    m.out_ready = 1'b0;
    issue(OP_REM, 32'hFFFFFFF9, 32'h00000002, 5'd15, 32'hFFFFFFFF, 32);
    wait_valid();
    repeat (5) @(posedge clk);
    #2;
    m.out_ready = 1'b1;
    wait_done();

    // Flush during the tenth CALC cycle, with a new request offered at the same time.
    start(OP_MUL, 32'h12345678, 32'h9ABCDEF0, 5'd17);
    repeat (9) @(posedge clk);
    #2;
    chk("busy_calc", 32'(m.busy_o), 32'd1);
    m.flush = 1'b1; m.in_valid = 1'b1;
    @(posedge clk); #1;
    m.flush = 1'b0; m.in_valid = 1'b0;
    chk("flush_in_ready", 32'(m.in_ready), 32'd1);
    chk("flush_busy", 32'(m.busy_o), 32'd0);
    chk("flush_out_valid", 32'(m.out_valid), 32'd0);
    repeat (40) @(posedge clk);
    #2;

    // Reset in the middle of CALC.
    start(OP_DIVU, 32'hDEADBEEF, 32'h00000013, 5'd18);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_calc_in_ready", 32'(m.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_calc_out_valid", 32'(m.out_valid), 32'd0);
    chk("rst_calc_busy", 32'(m.busy_o), 32'd0);
    chk("rst_calc_wdata", m.rd_wdata_o, 32'd0);
    chk("rst_calc_waddr", 32'(m.rd_waddr_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_calc_ready_after", 32'(m.in_ready), 32'd1);
    repeat (40) @(posedge clk);
    #2;

    // Reset while a result waits in DONE.
    m.out_ready = 1'b0;
    issue(OP_DIVU, 32'h00000007, 32'h00000000, 5'd20, 32'hFFFFFFFF, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m.out_ready = 1'b1;
    chk("rst_done_out_valid", 32'(m.out_valid), 32'd0);
    chk("rst_done_busy", 32'(m.busy_o), 32'd0);
    repeat (5) @(posedge clk);
    #2;

    // 16-bit build.
    issue16(OP_MUL,   16'h000F, 16'h0003, 32'h0000002D, 16);
    issue16(OP_MULHU, 16'hFFFF, 16'hFFFF, 32'h0000FFFE, 16);
    issue16(OP_DIV,   16'h8000, 16'hFFFF, 32'h00008000, 0);
    issue16(OP_REM,   16'hFFF9, 16'h0002, 32'h0000FFFF, 16);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()) + 32'(sb16.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
